// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: shadows the running time, edits one digit at a time, commits via set_valid. Optional WATCH_SET_TIMEOUT_EN aborts idle edits.
// Latency: one cycle from a button pulse to the registered outputs; no backpressure, since every button pulse is consumed in the cycle it arrives.
module watch_set_ctrl #(
    parameter int BLINK_HALF    = 20,
    parameter int TIMEOUT_TICKS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_100hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sw_mode,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    output logic       edit_en,
    output logic [1:0] i_num,
    output logic [5:0] tick_cnt,
    output logic       set_valid,
    output logic [5:0] set_sec,
    output logic [5:0] set_min,
    output logic [4:0] set_hour
);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    localparam logic [5:0] TICK_MAX = 6'(2 * BLINK_HALF - 1);

    // The inactivity counter is 10 bits wide, so larger limits cannot be reached.
    if (TIMEOUT_TICKS > 1023 || TIMEOUT_TICKS < 1) begin : g_timeout_out_of_range
    end

    state_t     state_q, state_d;
    logic       edit_en_q, edit_en_d;
    logic [1:0] i_num_q, i_num_d;
    logic [5:0] tick_cnt_q, tick_cnt_d;
    logic       set_valid_q, set_valid_d;
    logic [5:0] set_sec_q, set_sec_d;
    logic [5:0] set_min_q, set_min_d;
    logic [4:0] set_hour_q, set_hour_d;
    logic       sw_mode_q, sw_mode_d;
    logic [6:0] step_res;
`ifdef WATCH_SET_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_TICKS - 1);
    logic [9:0] to_cnt_q, to_cnt_d;
`endif

    function automatic logic [6:0] wrap_step(input logic [6:0] val, input logic [6:0] step,
                                             input logic [6:0] range, input logic up);
        logic [6:0] r;
        if (up) begin
            r = val + step;
            if (r >= range) r = r - range;
        end else if (val >= step) begin
            r = val - step;
        end else begin
            r = val + range - step;
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        i_num_d    = i_num_q;
        tick_cnt_d = tick_cnt_q;
        set_sec_d  = set_sec_q;
        set_min_d  = set_min_q;
        set_hour_d = set_hour_q;
        sw_mode_d  = sw_mode;
        step_res   = 7'd0;
`ifdef WATCH_SET_TIMEOUT_EN
        to_cnt_d   = 10'd0;
`endif

        case (state_q)
            IDLE: begin
                if (btn_mode) begin
                    set_sec_d  = cur_sec;
                    set_min_d  = cur_min;
                    set_hour_d = cur_hour;
                    i_num_d    = sw_mode ? 2'd0 : 2'd2;
                    state_d    = EDIT;
                end
            end
            EDIT: begin
                if (tick_100hz)
                    tick_cnt_d = (tick_cnt_q == TICK_MAX) ? 6'd0 : tick_cnt_q + 6'd1;
                if (btn_up || btn_down)
                    tick_cnt_d = 6'd0;

                if (btn_mode) begin
                    state_d = COMMIT;
                end else if (sw_mode != sw_mode_q) begin
                    // A view switch re-targets the cursor; edits in that cycle are dropped.
                    i_num_d = sw_mode ? 2'd0 : 2'd2;
                end else if (btn_next) begin
                    if (sw_mode) i_num_d = i_num_q + 2'd1;
                    else         i_num_d = (i_num_q == 2'd2) ? 2'd3 : 2'd2;
                end else if (btn_up ^ btn_down) begin
                    if (sw_mode) begin
                        case (i_num_q)
                            2'd0: begin
                                step_res  = wrap_step({1'b0, set_min_q}, 7'd1, 7'd60, btn_up);
                                set_min_d = step_res[5:0];
                            end
                            2'd1: begin
                                step_res  = wrap_step({1'b0, set_min_q}, 7'd10, 7'd60, btn_up);
                                set_min_d = step_res[5:0];
                            end
                            2'd2: begin
                                step_res   = wrap_step({2'b00, set_hour_q}, 7'd1, 7'd24, btn_up);
                                set_hour_d = step_res[4:0];
                            end
                            default: begin
                                step_res   = wrap_step({2'b00, set_hour_q}, 7'd10, 7'd24, btn_up);
                                set_hour_d = step_res[4:0];
                            end
                        endcase
                    end else if (i_num_q == 2'd2) begin
                        step_res  = wrap_step({1'b0, set_sec_q}, 7'd1, 7'd60, btn_up);
                        set_sec_d = step_res[5:0];
                    end else if (i_num_q == 2'd3) begin
                        step_res  = wrap_step({1'b0, set_sec_q}, 7'd10, 7'd60, btn_up);
                        set_sec_d = step_res[5:0];
                    end
                end

`ifdef WATCH_SET_TIMEOUT_EN
                if (btn_mode || btn_next || btn_up || btn_down) begin
                    to_cnt_d = 10'd0;
                end else if (tick_100hz) begin
                    if (to_cnt_q == TO_LAST) state_d = IDLE;
                    else                     to_cnt_d = to_cnt_q + 10'd1;
                end else begin
                    to_cnt_d = to_cnt_q;
                end
`endif
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != EDIT)
            tick_cnt_d = 6'd0;
        edit_en_d   = (state_d == EDIT);
        set_valid_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            edit_en_q   <= 1'b0;
            i_num_q     <= 2'd0;
            tick_cnt_q  <= 6'd0;
            set_valid_q <= 1'b0;
            set_sec_q   <= 6'd0;
            set_min_q   <= 6'd0;
            set_hour_q  <= 5'd0;
            sw_mode_q   <= 1'b0;
`ifdef WATCH_SET_TIMEOUT_EN
            to_cnt_q    <= 10'd0;
`endif
        end else begin
            state_q     <= state_d;
            edit_en_q   <= edit_en_d;
            i_num_q     <= i_num_d;
            tick_cnt_q  <= tick_cnt_d;
            set_valid_q <= set_valid_d;
            set_sec_q   <= set_sec_d;
            set_min_q   <= set_min_d;
            set_hour_q  <= set_hour_d;
            sw_mode_q   <= sw_mode_d;
`ifdef WATCH_SET_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign edit_en   = edit_en_q;
    assign i_num     = i_num_q;
    assign tick_cnt  = tick_cnt_q;
    assign set_valid = set_valid_q;
    assign set_sec   = set_sec_q;
    assign set_min   = set_min_q;
    assign set_hour  = set_hour_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: entry, digit walk, wrap arithmetic, blink phase, commit, reset abort, timeout.
module tb_watch_set_ctrl;

`ifdef WATCH_SET_TIMEOUT_EN
    localparam int TO_TICKS = 5;
`else
    localparam int TO_TICKS = 1000;
`endif
    localparam int N_TICKS = (TO_TICKS > 45) ? 45 : TO_TICKS - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_100hz = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       sw_mode = 1'b0;
    logic [5:0] cur_sec = 6'd0, cur_min = 6'd0;
    logic [4:0] cur_hour = 5'd0;
    logic       edit_en, set_valid;
    logic [1:0] i_num;
    logic [5:0] tick_cnt, set_sec, set_min;
    logic [4:0] set_hour;

    int compared = 0;
    int mismatched = 0;
    int sv_cnt = 0;
    int sv_base;

    watch_set_ctrl #(.BLINK_HALF(20), .TIMEOUT_TICKS(TO_TICKS)) dut (
        .clk(clk), .reset(reset), .tick_100hz(tick_100hz),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .sw_mode(sw_mode), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .edit_en(edit_en), .i_num(i_num), .tick_cnt(tick_cnt), .set_valid(set_valid),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later and all pulses drop.
    task automatic step();
        @(posedge clk);
        #1;
        if (set_valid === 1'b1) sv_cnt++;
        btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick_100hz = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur_sec = 6'd33; cur_min = 6'd44; cur_hour = 5'd11;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_edit_en", 32'(edit_en), 0);
        chk("rst_i_num", 32'(i_num), 0);
        chk("rst_tick_cnt", 32'(tick_cnt), 0);
        chk("rst_set_valid", 32'(set_valid), 0);
        chk("rst_set_sec", 32'(set_sec), 0);
        chk("rst_set_min", 32'(set_min), 0);
        chk("rst_set_hour", 32'(set_hour), 0);

        // Enter edit in min/hour view.
        sw_mode = 1'b1; cur_min = 6'd59; cur_hour = 5'd23; cur_sec = 6'd30;
        btn_mode = 1'b1; step();
        chk("enter_edit_en", 32'(edit_en), 1);
        chk("enter_i_num", 32'(i_num), 0);
        chk("enter_set_min", 32'(set_min), 59);
        chk("enter_set_hour", 32'(set_hour), 23);
        chk("enter_set_sec", 32'(set_sec), 30);

        btn_up = 1'b1; step();
        chk("min59_up", 32'(set_min), 0);
        btn_next = 1'b1; step();
        chk("next_to_1", 32'(i_num), 1);
        btn_next = 1'b1; step();
        chk("next_to_2", 32'(i_num), 2);
        btn_up = 1'b1; step();
        chk("hour23_up", 32'(set_hour), 0);
        btn_next = 1'b1; step();
        chk("next_to_3", 32'(i_num), 3);
        btn_down = 1'b1; step();
        chk("hour0_down10", 32'(set_hour), 14);
        btn_up = 1'b1; step();
        chk("hour14_up10", 32'(set_hour), 0);
        btn_next = 1'b1; step();
        chk("next_wrap_0", 32'(i_num), 0);
        btn_down = 1'b1; step();
        chk("min0_down", 32'(set_min), 59);
        btn_next = 1'b1; step();
        btn_down = 1'b1; step();
        chk("min59_down10", 32'(set_min), 49);
        btn_up = 1'b1; step();
        btn_up = 1'b1; step();
        chk("min59_up10", 32'(set_min), 9);

        // Blink phase counts ticks and wraps at 39.
        for (int k = 0; k < N_TICKS; k++) begin
            tick_100hz = 1'b1; step();
            chk("tick_seq", 32'(tick_cnt), 32'((k + 1) % 40));
        end
        btn_up = 1'b1; step();
        chk("up_clears_tick", 32'(tick_cnt), 0);
        chk("min9_up10", 32'(set_min), 19);
        tick_100hz = 1'b1; btn_up = 1'b1; step();
        chk("tick_up_same", 32'(tick_cnt), 0);
        chk("min19_up10", 32'(set_min), 29);

        // btn_mode outranks btn_up: commit with the field untouched.
        sv_base = sv_cnt;
        btn_mode = 1'b1; btn_up = 1'b1; step();
        chk("commit_valid", 32'(set_valid), 1);
        chk("commit_min", 32'(set_min), 29);
        chk("commit_hour", 32'(set_hour), 0);
        step();
        chk("post_commit_valid", 32'(set_valid), 0);
        chk("post_commit_edit", 32'(edit_en), 0);
        chk("commit_pulses", 32'(sv_cnt - sv_base), 1);

        // Shadows hold in IDLE regardless of the running time.
        cur_min = 6'd1; cur_hour = 5'd2; step();
        chk("idle_hold_min", 32'(set_min), 29);

        // Seconds view.
        sw_mode = 1'b0; cur_sec = 6'd7; btn_mode = 1'b1; step();
        chk("sec_enter_i_num", 32'(i_num), 2);
        chk("sec_enter_val", 32'(set_sec), 7);
        btn_next = 1'b1; step();
        chk("sec_next_3", 32'(i_num), 3);
        btn_down = 1'b1; step();
        chk("sec7_down10", 32'(set_sec), 57);
        btn_next = 1'b1; step();
        chk("sec_next_2", 32'(i_num), 2);
        tick_100hz = 1'b1; step();
        btn_up = 1'b1; btn_down = 1'b1; step();
        chk("updown_no_change", 32'(set_sec), 57);
        chk("updown_tick_clr", 32'(tick_cnt), 0);
        sv_base = sv_cnt;
        btn_mode = 1'b1; step();
        chk("sec_commit_valid", 32'(set_valid), 1);
        chk("sec_commit_val", 32'(set_sec), 57);
        step();
        chk("sec_post_valid", 32'(set_valid), 0);
        chk("sec_post_edit", 32'(edit_en), 0);
        chk("sec_pulses", 32'(sv_cnt - sv_base), 1);

        // View switch while editing re-targets the cursor.
        btn_mode = 1'b1; step();
        btn_next = 1'b1; step();
        chk("sw_pre_i_num", 32'(i_num), 3);
        sw_mode = 1'b1; step();
        chk("sw_to_minhour", 32'(i_num), 0);
        sw_mode = 1'b0; step();
        chk("sw_to_sec", 32'(i_num), 2);

        // Reset mid-edit discards without a load strobe.
        sv_base = sv_cnt;
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rst_edit_abort", 32'(edit_en), 0);
        chk("rst_edit_sec", 32'(set_sec), 0);
        step();
        chk("rst_no_valid", 32'(sv_cnt - sv_base), 0);

        // Inactivity behaviour.
        sw_mode = 1'b1; btn_mode = 1'b1; step();
        sv_base = sv_cnt;
`ifdef WATCH_SET_TIMEOUT_EN
        repeat (TO_TICKS - 1) begin tick_100hz = 1'b1; step(); end
        chk("to_before_limit", 32'(edit_en), 1);
        btn_next = 1'b1; step();
        repeat (TO_TICKS - 1) begin tick_100hz = 1'b1; step(); end
        chk("to_btn_restarts", 32'(edit_en), 1);
        tick_100hz = 1'b1; step();
        chk("to_abort_edit", 32'(edit_en), 0);
        step();
        chk("to_no_valid", 32'(sv_cnt - sv_base), 0);
`else
        repeat (2000) begin tick_100hz = 1'b1; step(); end
        chk("no_to_still_edit", 32'(edit_en), 1);
        chk("no_to_no_valid", 32'(sv_cnt - sv_base), 0);
        btn_mode = 1'b1; step();
        chk("no_to_commit", 32'(set_valid), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
Edit-mode controller for the watch display path. It sequences time setting: it captures the running time into shadow registers, selects the digit being edited, and generates the blink phase that drives the FND watch controller (edit_en→sw_mode_2, i_num, tick_cnt). On exit it commits the edited hour/min/sec to the watch counter through a one-cycle load pulse.

Parameters:
BLINK_HALF, 20, tick_100hz periods for which the selected digit is visible; tick_cnt wraps at 2*BLINK_HALF-1
TIMEOUT_TICKS, 1000, tick_100hz periods with no button activity before edit is aborted (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_100hz  in  1  one-cycle pulse at 100 Hz from the time base
btn_mode  in  1  debounced one-cycle pulse: enter or commit edit
btn_next  in  1  debounced one-cycle pulse: advance edited digit
btn_up  in  1  debounced one-cycle pulse: increment selected field
btn_down  in  1  debounced one-cycle pulse: decrement selected field
sw_mode  in  1  view select: 0 = sec view, 1 = min/hour view
cur_sec  in  6  running seconds, 0..59
cur_min  in  6  running minutes, 0..59
cur_hour  in  5  running hours, 0..23
edit_en  out  1  high in EDIT; drives sw_mode_2
i_num  out  2  selected digit: 0 = min ones, 1 = min tens, 2 = hour ones / sec ones, 3 = hour tens / sec tens
tick_cnt  out  6  blink phase, 0..2*BLINK_HALF-1
set_valid  out  1  one-cycle load strobe to the watch counter
set_sec  out  6  shadow seconds
set_min  out  6  shadow minutes
set_hour  out  5  shadow hours

Behaviour:
- Registered outputs. Reset values: edit_en=0, i_num=0, tick_cnt=0, set_valid=0, set_sec=0, set_min=0, set_hour=0. The FSM resets to IDLE. Reset during EDIT discards the edit and produces no set_valid.
- FSM states: IDLE, EDIT, COMMIT.
- IDLE: tick_cnt held at 0. On btn_mode, load shadow regs from cur_*. Set i_num = 0 when sw_mode=1 and 2 when sw_mode=0. Next state EDIT; edit_en=1 from the next cycle.
- EDIT:
  - tick_cnt increments on each tick_100hz and wraps from 2*BLINK_HALF-1 to 0.
  - Any btn_up or btn_down press clears tick_cnt to 0 in that cycle, so the digit is visible immediately.
- Priority within one cycle: btn_mode > btn_next > btn_up/btn_down. btn_up and btn_down asserted together: no field change, tick_cnt still cleared.
- btn_next: in min/hour view, i_num = (i_num+1) mod 4. In sec view, i_num toggles between 2 and 3.
- A sw_mode change during EDIT forces i_num to 0 (new value 1) or 2 (new value 0) on the next cycle.
- Field arithmetic. Up adds and down subtracts, modulo the field range, with wrap in both directions:
  - min/hour view: i_num0 min ±1 mod 60; i_num1 min ±10 mod 60; i_num2 hour ±1 mod 24; i_num3 hour ±10 mod 24.
  - sec view: i_num2 sec ±1 mod 60; i_num3 sec ±10 mod 60.
  - Examples: min 59 +1 → 0; min 5 −10 → 55; hour 20 +10 → 6; hour 3 −10 → 17.
- btn_mode in EDIT → COMMIT. COMMIT lasts exactly one cycle with set_valid=1 and set_* holding the final shadow values. Then IDLE with edit_en=0.
- Latency: button pulse at cycle N → output change visible at cycle N+1.
- set_* hold their last values in IDLE.

Optional Feature:
WATCH_SET_TIMEOUT_EN:
- Defined: a 10-bit inactivity counter counts tick_100hz in EDIT. Any btn_* pulse or entry into EDIT clears it. On reaching TIMEOUT_TICKS, the FSM returns to IDLE with no set_valid (edit aborted).
- Undefined: no counter; EDIT persists until btn_mode or reset.

Test Plan:
- Reset, then sw_mode=1, cur_min=59, cur_hour=23, btn_mode → next cycle edit_en=1, i_num=0, set_min=59, set_hour=23.
- In EDIT (min/hour view) btn_up at i_num0 → set_min=0; btn_next×2 then btn_up → set_hour=0; btn_next then btn_down at i_num3 (hour 0) → set_hour=14.
- 45 tick_100hz pulses in EDIT → tick_cnt sequence 0..39, 0..4; then btn_up → tick_cnt=0 next cycle.
- sw_mode=0, enter edit with cur_sec=7 → i_num=2; btn_next → i_num=3; btn_down → set_sec=57; btn_next → i_num=2; btn_mode → exactly one set_valid cycle with set_sec=57, then edit_en=0.
- Same cycle btn_mode+btn_up in EDIT → COMMIT with unchanged field. btn_up+btn_down together → no change. Reset asserted in EDIT → edit_en=0, set_valid never asserted.
- With WATCH_SET_TIMEOUT_EN and TIMEOUT_TICKS=5: enter EDIT, 5 ticks with no buttons → edit_en=0, set_valid stays 0. Without the macro: still in EDIT after 2000 ticks.
